// File: rtl/io_sequencer.sv
// rtl/io_sequencer.sv - four-phase I/O bus sequencer for one device operation
//
// Runs one I/O instruction (opcode 0..7) against a device over a four-phase
// req/ack handshake, with an abort after TIMEOUT cycles of unanswered request.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, op, dev, wdata  operation request (sampled only when idle)
//   busy, done             status; done is a one-cycle completion pulse
//   rdata, skip, timeout   results, valid from done until the next start
//   io_req .. io_wdata     bus request side (all registered)
//   io_ack, io_rdata       device response

module io_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [6:0]  dev,
    input  logic [35:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [35:0] rdata,
    output logic        skip,
    output logic        timeout,
    output logic        io_req,
    output logic        io_write,
    output logic        io_cond_sel,
    output logic [6:0]  io_dev_o,
    output logic [35:0] io_wdata,
    input  logic        io_ack,
    input  logic [35:0] io_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_REL,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        busy_q;
    logic        done_q;
    logic [35:0] rdata_q;
    logic        skip_q;
    logic        timeout_q;
    logic        io_req_q;
    logic        io_write_q;
    logic        io_cond_sel_q;
    logic [6:0]  io_dev_q;
    logic [35:0] io_wdata_q;

    // The latched write data doubles as the test mask for CONSZ/CONSO.
    logic        mask_hit;
    logic        skip_d;

    always_comb begin
        cnt_d    = cnt_q + 8'd1;
        mask_hit = |(io_rdata & io_wdata_q);
        skip_d   = 1'b0;
        if (op_q == 3'd6) begin
            skip_d = ~mask_hit;
        end else if (op_q == 3'd7) begin
            skip_d = mask_hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            cnt_q         <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= 36'd0;
            skip_q        <= 1'b0;
            timeout_q     <= 1'b0;
            io_req_q      <= 1'b0;
            io_write_q    <= 1'b0;
            io_cond_sel_q <= 1'b0;
            io_dev_q      <= 7'd0;
            io_wdata_q    <= 36'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q          <= op;
                        io_write_q    <= (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
                        io_cond_sel_q <= op[2];
                        io_dev_q      <= dev;
                        io_wdata_q    <= wdata;
                        rdata_q       <= 36'd0;
                        skip_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        cnt_q         <= 8'd0;
                        io_req_q      <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack arriving on the final allowed cycle still wins.
                    if (io_ack) begin
                        if (!io_write_q) begin
                            rdata_q <= io_rdata;
                            skip_q  <= skip_d;
                        end
                        io_req_q <= 1'b0;
                        state_q  <= S_REL;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        rdata_q   <= 36'd0;
                        skip_q    <= 1'b0;
                        io_req_q  <= 1'b0;
                        state_q   <= S_REL;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_REL: begin
                    if (!io_ack) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign skip        = skip_q;
    assign timeout     = timeout_q;
    assign io_req      = io_req_q;
    assign io_write    = io_write_q;
    assign io_cond_sel = io_cond_sel_q;
    assign io_dev_o    = io_dev_q;
    assign io_wdata    = io_wdata_q;

endmodule

// File: tb/tb_io_sequencer.sv
// tb/tb_io_sequencer.sv - self-checking bench for io_sequencer

module tb_io_sequencer;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [6:0]  dev;
    logic [35:0] wdata;
    logic        busy;
    logic        done;
    logic [35:0] rdata;
    logic        skip;
    logic        timeout;
    logic        io_req;
    logic        io_write;
    logic        io_cond_sel;
    logic [6:0]  io_dev_o;
    logic [35:0] io_wdata;
    logic        io_ack;
    logic [35:0] io_rdata;

    int checks   = 0;
    int failures = 0;

    io_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .dev         (dev),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .skip        (skip),
        .timeout     (timeout),
        .io_req      (io_req),
        .io_write    (io_write),
        .io_cond_sel (io_cond_sel),
        .io_dev_o    (io_dev_o),
        .io_wdata    (io_wdata),
        .io_ack      (io_ack),
        .io_rdata    (io_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation with a scripted device: ack rises ack_delay cycles after
    // io_req first rises and stays high for hold cycles. ack_delay >= TIMEOUT
    // means the device never answers. Expected behaviour is derived from the
    // operation's rules, then compared cycle by cycle.
    task automatic run_op(input logic [2:0] o, input logic [6:0] d, input logic [35:0] w,
                          input logic [35:0] rd, input int ack_delay, input int hold,
                          input bit poke_start);
        bit          to_exp;
        bit          is_write;
        int          req_cycles;
        int          done_cyc;
        logic [35:0] exp_rdata;
        logic        exp_skip;
        bit          ack_now;

        to_exp     = (ack_delay >= TIMEOUT);
        is_write   = (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
        req_cycles = to_exp ? TIMEOUT : ack_delay + 1;
        done_cyc   = to_exp ? TIMEOUT + 2 : ack_delay + hold + 2;
        exp_rdata  = (!to_exp && !is_write) ? rd : 36'd0;
        exp_skip   = !to_exp && (((o == 3'd6) && ((rd & w) == 36'd0)) ||
                                 ((o == 3'd7) && ((rd & w) != 36'd0)));

        start = 1'b1; op = o; dev = d; wdata = w; io_ack = 1'b0;
        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            @(posedge clk); #1;
            chk("io_req",      io_req,      (cyc <= req_cycles));
            chk("busy",        busy,        (cyc <= done_cyc));
            chk("done",        done,        (cyc == done_cyc));
            chk("io_write",    io_write,    is_write);
            chk("io_cond_sel", io_cond_sel, o[2]);
            chk("io_dev_o",    io_dev_o,    d);
            chk("io_wdata",    io_wdata,    w);
            if (cyc >= done_cyc) begin
                chk("rdata",   rdata,   exp_rdata);
                chk("skip",    skip,    exp_skip);
                chk("timeout", timeout, to_exp);
            end
            // Inputs change every cycle so that any unlatched use shows up.
            start    = poke_start && (cyc == 2);
            op       = 3'($urandom_range(0, 7));
            dev      = 7'($urandom);
            wdata    = rnd36();
            ack_now  = !to_exp && (cyc >= ack_delay + 1) && (cyc <= ack_delay + hold);
            io_ack   = ack_now;
            io_rdata = ack_now ? rd : rnd36();
        end
        start  = 1'b0;
        io_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 3'd0; dev = 7'd0; wdata = 36'd0;
        io_ack = 1'b0; io_rdata = 36'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     busy,     1'b0);
        chk("rst_done",     done,     1'b0);
        chk("rst_io_req",   io_req,   1'b0);
        chk("rst_io_write", io_write, 1'b0);
        chk("rst_io_dev",   io_dev_o, 7'd0);
        chk("rst_io_wdata", io_wdata, 36'd0);
        chk("rst_rdata",    rdata,    36'd0);
        chk("rst_timeout",  timeout,  1'b0);
        reset_n = 1'b1;

        // ack while idle is ignored
        @(posedge clk); #1;
        io_ack = 1'b1; io_rdata = rnd36();
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_ack_busy", busy,   1'b0);
            chk("idle_ack_req",  io_req, 1'b0);
        end
        io_ack = 1'b0;
        @(posedge clk); #1;

        run_op(3'd1, 7'o4, 36'd0, 36'o123456, 2, 1, 1'b0);
        run_op(3'd7, 7'o10, 36'o10, 36'o30, 0, 1, 1'b0);
        run_op(3'd6, 7'o10, 36'o10, 36'o30, 1, 1, 1'b0);
        run_op(3'd6, 7'o10, 36'o10, 36'o20, 0, 2, 1'b0);
        run_op(3'd3, 7'o21, 36'o777777000000, rnd36(), 0, 1, 1'b0);
        run_op(3'd0, 7'o3, rnd36(), rnd36(), 1000, 1, 1'b0);
        run_op(3'd5, 7'o3, rnd36(), 36'o707070, TIMEOUT - 1, 1, 1'b0);
        run_op(3'd2, 7'o7, rnd36(), rnd36(), TIMEOUT - 2, 3, 1'b0);
        run_op(3'd1, 7'o12, rnd36(), 36'o55, 0, 5, 1'b1);

        // reset in the middle of REQ
        start = 1'b1; op = 3'd3; dev = 7'o33; wdata = rnd36(); io_ack = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_req", io_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_req",   io_req,   1'b0);
        chk("async_rst_busy",  busy,     1'b0);
        chk("async_rst_wdata", io_wdata, 36'd0);
        chk("async_rst_dev",   io_dev_o, 7'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_no_done", done, 1'b0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done, 1'b0);
        run_op(3'd5, 7'o44, rnd36(), 36'o4321, 1, 1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_op(3'($urandom_range(0, 7)), 7'($urandom), rnd36(), rnd36(),
                   $urandom_range(0, 6), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
